padin_cond: RTL
===============

Name: padin_cond

Overview:
- Input-conditioning stage directly downstream of the layer-0 IN_PAD cells; consumes the pad core-side outputs (X0_OUT, X1_OUT, X34_OUT) before they reach core logic or inter-layer TSVs.
- Per channel: synchronizes the pad signal into the clk1 domain and applies a stability-count deglitch filter.
- Produces clean levels plus single-cycle rise/fall event pulses for the core.

Parameters:
- NUM_IN, 3, number of pad channels (bit 0 = X0, bit 1 = X1, bit 2 = X34).
- SYNC_STAGES, 2, synchronizer flop depth; legal range 2..4.
- FILT_LEN, 8, consecutive cycles a new synced value must persist before it is accepted; legal range 1..(2^FILT_CNT_W - 1).
- FILT_CNT_W, 4, width of the per-channel stability counter.

Ports:
- clk1  input  1  core clock, taken from the clk1 IN_PAD output.
- rst_n  input  1  asynchronous active-low reset.
- pad_i  input  NUM_IN  raw pad core-side outputs, asynchronous to clk1.
- filt_bypass_i  input  1  when 1, the filter is skipped and the synced value drives filt_o directly.
- filt_o  output  NUM_IN  filtered levels.
- rise_o  output  NUM_IN  one-cycle pulse when filt_o goes 0->1.
- fall_o  output  NUM_IN  one-cycle pulse when filt_o goes 1->0.

Behaviour:
- Reset is asynchronous assert and synchronous deassert (external). On reset, all sync flops, counters, filt_o and its delayed copy are 0; rise_o = fall_o = 0.
- Sync: a SYNC_STAGES-deep flop chain per bit; sync_q is the last stage. A pad change is visible on sync_q after exactly SYNC_STAGES clk1 edges.
- Filter, per channel, evaluated each edge:
  - If sync_q == filt_o, cnt <= 0.
  - Otherwise, if cnt == FILT_LEN-1: filt_o <= sync_q and cnt <= 0.
  - Otherwise, cnt <= cnt + 1.
- Filter consequences:
  - Latency from pad change to filt_o change is SYNC_STAGES + FILT_LEN edges.
  - A pulse shorter than FILT_LEN cycles at sync_q is fully suppressed.
  - Any reversion to the current filt_o value restarts the count from 0.
- FILT_LEN = 1 means filt_o follows sync_q with one edge of delay.
- The counter never exceeds FILT_LEN-1 and never wraps.
- Bypass:
  - While filt_bypass_i = 1: filt_o <= sync_q every edge and cnt is held at 0.
  - Toggling bypass mid-count discards the partial count; there is no glitch beyond the level change itself.
- Edges: filt_d <= filt_o; rise_o = filt_o & ~filt_d; fall_o = ~filt_o & filt_d.
  - Each pulse is exactly 1 cycle and coincides with the first cycle of the new filt_o level.
  - rise_o and fall_o are never high together on the same bit.
- Channels are fully independent; simultaneous events on several bits are all reported in the same cycle.
- Reset mid-count discards all state. After deassertion the pad value is re-acquired from 0, with full latency.

Optional Feature:
- Macro PADIN_COND_STICKY_EN.
- When defined:
  - Adds input clr_i (1 bit) and output evt_sticky_o (NUM_IN).
  - Bit n sets on rise_o[n] | fall_o[n] and holds until clr_i = 1.
  - A set in the same cycle as clr_i wins, so no event is lost.
  - Reset value is 0.
- When undefined: neither port nor logic exists.

Decomposition:
- Package padin_cond_pkg holds the channel index constants (CH_X0 = 0, CH_X1 = 1, CH_X34 = 2), the default FILT_LEN and SYNC_STAGES, and the filter-counter typedef.
- Sub-module padin_filt_ch implements one channel (sync chain, counter, filt_d, edge logic). The top generates NUM_IN instances and, when enabled, the sticky register.

Test Plan:
Defaults unless stated (SYNC_STAGES = 2, FILT_LEN = 8).
- Reset: hold rst_n = 0 with pad_i = 3'b111 -> all outputs 0. Release, keep pad high -> filt_o = 3'b111 exactly 10 edges later; rise_o = 3'b111 for 1 cycle.
- Glitch reject: 5-cycle high pulse on pad_i[0] -> filt_o[0], rise_o[0] and fall_o[0] stay 0.
- Accept and return: 12-cycle high pulse on pad_i[1] -> rise_o[1] at edge 10, fall_o[1] 12 cycles later, each pulse 1 cycle wide.
- Restart: high for 7 cycles, low for 1, high for 8 -> only the final 8-cycle run is accepted; rise_o asserts 10 edges after it starts.
- Bypass and boundaries:
  - filt_bypass_i = 1 with a 1-cycle pad pulse -> filt_o pulse 1 cycle wide, 3 edges after the pad change.
  - FILT_LEN = 1 build -> latency of 3 edges.
  - Reset asserted mid-count -> outputs clear immediately.
- Sticky (PADIN_COND_STICKY_EN): rise on X34 -> evt_sticky_o[2] = 1 until clr_i. An event coinciding with clr_i leaves the bit set.

Source files
------------

// File: rtl/padin_cond_pkg.sv
// Shared constants and types for the pad-input conditioning block.
package padin_cond_pkg;

    localparam int unsigned NUM_IN_DEF      = 3;
    localparam int unsigned CH_X0           = 0;
    localparam int unsigned CH_X1           = 1;
    localparam int unsigned CH_X34          = 2;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FILT_LEN_DEF    = 8;
    localparam int unsigned FILT_CNT_W_DEF  = 4;

    typedef logic [FILT_CNT_W_DEF-1:0] filt_cnt_t;

endpackage

// File: rtl/padin_cond_if.sv
// Pad-side and core-side signal bundle of padin_cond.
// Optional sticky event port: PADIN_COND_STICKY_EN.
interface padin_cond_if #(
    parameter int unsigned NUM_IN = padin_cond_pkg::NUM_IN_DEF
);
    logic [NUM_IN-1:0] pad_i;
    logic              filt_bypass_i;
    logic [NUM_IN-1:0] filt_o;
    logic [NUM_IN-1:0] rise_o;
    logic [NUM_IN-1:0] fall_o;
`ifdef PADIN_COND_STICKY_EN
    logic              clr_i;
    logic [NUM_IN-1:0] evt_sticky_o;

    modport master (
        output pad_i, filt_bypass_i, clr_i,
        input  filt_o, rise_o, fall_o, evt_sticky_o
    );
    modport slave (
        input  pad_i, filt_bypass_i, clr_i,
        output filt_o, rise_o, fall_o, evt_sticky_o
    );
`else
    modport master (
        output pad_i, filt_bypass_i,
        input  filt_o, rise_o, fall_o
    );
    modport slave (
        input  pad_i, filt_bypass_i,
        output filt_o, rise_o, fall_o
    );
`endif
endinterface

// File: rtl/padin_filt_ch.sv
// One pad channel: clk1 synchronizer, stability-count deglitch filter and
// registered rise/fall pulses aligned with the first cycle of the new level.
module padin_filt_ch
    import padin_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILT_LEN    = FILT_LEN_DEF,
    parameter int unsigned FILT_CNT_W  = FILT_CNT_W_DEF
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic pad_i,
    input  logic filt_bypass_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);
    localparam logic [FILT_CNT_W-1:0] CNT_ONE  = FILT_CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [FILT_CNT_W-1:0]  cnt_q;
    logic [FILT_CNT_W-1:0]  cnt_nxt;
    logic                   filt_q;
    logic                   filt_nxt;
    logic                   rise_q;
    logic                   rise_nxt;
    logic                   fall_q;
    logic                   fall_nxt;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // State registers; the pulses are registered from the level transition.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            cnt_q  <= cnt_nxt;
            filt_q <= filt_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    // Accept a new synced level only after FILT_LEN consecutive samples.
    always_comb begin
        cnt_nxt  = cnt_q;
        filt_nxt = filt_q;
        if (filt_bypass_i) begin
            filt_nxt = sync_bit;
            cnt_nxt  = '0;
        end else if (sync_bit == filt_q) begin
            cnt_nxt  = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_nxt = sync_bit;
            cnt_nxt  = '0;
        end else begin
            cnt_nxt  = cnt_q + CNT_ONE;
        end
        rise_nxt = filt_nxt & ~filt_q;
        fall_nxt = ~filt_nxt & filt_q;
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/padin_cond.sv
// Conditions the layer-0 IN_PAD core-side outputs (X0, X1, X34) into clk1.
// Optional sticky event register: PADIN_COND_STICKY_EN.
module padin_cond
    import padin_cond_pkg::*;
#(
    parameter int unsigned NUM_IN      = NUM_IN_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILT_LEN    = FILT_LEN_DEF,
    parameter int unsigned FILT_CNT_W  = FILT_CNT_W_DEF
) (
    input  logic          clk1,
    input  logic          rst_n,
    padin_cond_if.slave   bus
);

    logic [NUM_IN-1:0] filt_w;
    logic [NUM_IN-1:0] rise_w;
    logic [NUM_IN-1:0] fall_w;

    for (genvar n = 0; n < NUM_IN; n++) begin : g_ch
        padin_filt_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .FILT_CNT_W  (FILT_CNT_W)
        ) u_ch (
            .clk1          (clk1),
            .rst_n         (rst_n),
            .pad_i         (bus.pad_i[n]),
            .filt_bypass_i (bus.filt_bypass_i),
            .filt_o        (filt_w[n]),
            .rise_o        (rise_w[n]),
            .fall_o        (fall_w[n])
        );
    end

    assign bus.filt_o = filt_w;
    assign bus.rise_o = rise_w;
    assign bus.fall_o = fall_w;

`ifdef PADIN_COND_STICKY_EN
    logic [NUM_IN-1:0] sticky_q;

    // New events override a coincident clear so none is lost.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~{NUM_IN{bus.clr_i}}) | rise_w | fall_w;
        end
    end

    assign bus.evt_sticky_o = sticky_q;
`endif

endmodule
